// File: rtl/mgmt_mdio_sequencer.sv
// mgmt_mdio_sequencer: accepts one PHY register read/write request at a time,
// issues a single-cycle command strobe to the MDIO transceiver, follows its
// busy flag through rise and fall, and returns exactly one response per
// request. A request that takes too long is abandoned and reported as a timeout.
//
// Handshake: a request transfers on a rising clk edge where
// req_valid && req_ready. req_ready is combinational and is high only in IDLE
// with the transceiver idle. resp_valid is a one-cycle strobe with no
// back-pressure. resp_rdata and resp_timeout are valid with resp_valid and
// hold their values until the next response.
module mgmt_mdio_sequencer #(
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_timeout,
  output logic        busy,
  output logic [7:0]  timeout_count,
  input  logic        mdio_busy,
  input  logic [15:0] phy_rd_data,
  output logic [4:0]  phy_reg_addr,
  output logic [15:0] phy_wr_data,
  output logic        phy_reg_wr,
  output logic        phy_reg_rd
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RESPOND = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            wr_lat;
  logic [CW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            accept;
  logic            done_ok;
  logic            tmo_fire;

  assign tmo_hit = (tmo_cnt == TMO_MAX);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the strobes/flags that follow directly from state.
  // A busy fall in WAIT_LO beats a simultaneous timeout.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    phy_reg_wr = 1'b0;
    phy_reg_rd = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    done_ok    = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: begin
        busy      = 1'b0;
        req_ready = !mdio_busy;
        if (req_valid && !mdio_busy) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        phy_reg_wr = wr_lat;
        phy_reg_rd = !wr_lat;
        state_nxt  = WAIT_HI;
      end
      WAIT_HI: begin
        if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = RESPOND;
        end else if (mdio_busy) begin
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!mdio_busy) begin
          done_ok   = 1'b1;
          state_nxt = RESPOND;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch: address and write data hold from one accept to the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_lat       <= 1'b0;
      phy_reg_addr <= 5'd0;
      phy_wr_data  <= 16'd0;
    end else if (accept) begin
      wr_lat       <= req_write;
      phy_reg_addr <= req_addr;
      phy_wr_data  <= req_write ? req_wdata : 16'd0;
    end
  end

  // Timeout counter: cleared on the strobe cycle, saturating in the wait states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE) begin
      tmo_cnt <= '0;
    end else if ((state == WAIT_HI || state == WAIT_LO) && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Response capture and saturating count of abandoned requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_rdata    <= 16'd0;
      resp_timeout  <= 1'b0;
      timeout_count <= 8'd0;
    end else if (done_ok) begin
      resp_rdata   <= wr_lat ? 16'd0 : phy_rd_data;
      resp_timeout <= 1'b0;
    end else if (tmo_fire) begin
      resp_rdata   <= 16'hFFFF;
      resp_timeout <= 1'b1;
      if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_mgmt_mdio_sequencer.sv
// Directed bench for mgmt_mdio_sequencer with a behavioural transceiver model
// and a response scoreboard (data, arrival cycle, timeout count).
module tb_mgmt_mdio_sequencer;

  localparam int TMO = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [4:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_timeout;
  logic        busy;
  logic [7:0]  timeout_count;
  logic        mdio_busy;
  logic [15:0] phy_rd_data = 16'h0000;
  logic [4:0]  phy_reg_addr;
  logic [15:0] phy_wr_data;
  logic        phy_reg_wr;
  logic        phy_reg_rd;

  logic        model_busy = 1'b0;
  logic        force_busy = 1'b0;
  int          model_len = 0;
  logic [15:0] model_rdata = 16'h0000;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int strb_seen = 0;
  int strb_exp = 0;
  int tc_model = 0;

  logic [16:0] exp_q[$];
  int          cyc_q[$];
  logic [7:0]  tc_q[$];
  logic [16:0] e_resp;
  int          e_cyc;
  logic [7:0]  e_tc;

  assign mdio_busy = model_busy | force_busy;

  mgmt_mdio_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_timeout (resp_timeout),
    .busy         (busy),
    .timeout_count(timeout_count),
    .mdio_busy    (mdio_busy),
    .phy_rd_data  (phy_rd_data),
    .phy_reg_addr (phy_reg_addr),
    .phy_wr_data  (phy_wr_data),
    .phy_reg_wr   (phy_reg_wr),
    .phy_reg_rd   (phy_reg_rd)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Transceiver model: busy rises right after the strobe, stays high
  // model_len cycles, read data appears as busy falls. model_len 0 = silent.
  always begin
    @(negedge clk);
    if ((phy_reg_wr || phy_reg_rd) && model_len > 0) begin
      @(posedge clk);
      #1 model_busy = 1'b1;
      phy_rd_data = 16'hA5A5;
      repeat (model_len) @(posedge clk);
      #1 phy_rd_data = model_rdata;
      model_busy = 1'b0;
    end
  end

  // Scoreboard: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (phy_reg_wr || phy_reg_rd) strb_seen++;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        e_resp = exp_q.pop_front();
        e_cyc  = cyc_q.pop_front();
        e_tc   = tc_q.pop_front();
        check("resp_data", {15'd0, resp_timeout, resp_rdata}, {15'd0, e_resp});
        check("resp_cycle", cyc, e_cyc);
        check("resp_tcount", timeout_count, e_tc);
      end
    end
  end

  // Driver: present a request, wait for accept, register expectations,
  // then check the strobe cycle and that the strobe lasts one cycle.
  task automatic send(input logic wr, input logic [4:0] addr, input logic [15:0] wd,
                      input int len, input logic [15:0] rd, input logic keep,
                      output int s);
    int n;
    logic tmo;
    n = 0;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    while (req_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("accept_wait", 32'd0, 32'd1);
      req_valid = 1'b0;
      s = -1;
      return;
    end
    s = cyc + 1;
    model_len   = len;
    model_rdata = rd;
    tmo = (len == 0) || (len > TMO);
    if (tmo) begin
      tc_model = (tc_model < 255) ? tc_model + 1 : 255;
      exp_q.push_back({1'b1, 16'hFFFF});
      cyc_q.push_back(s + TMO + 2);
    end else begin
      exp_q.push_back({1'b0, (wr ? 16'h0000 : rd)});
      cyc_q.push_back(s + 2 + len);
    end
    tc_q.push_back(8'(tc_model));
    strb_exp++;
    @(posedge clk);
    #1 if (!keep) req_valid = 1'b0;
    @(negedge clk);
    check("strobe_wr", {31'd0, phy_reg_wr}, {31'd0, wr});
    check("strobe_rd", {31'd0, phy_reg_rd}, {31'd0, !wr});
    check("phy_addr", {27'd0, phy_reg_addr}, {27'd0, addr});
    check("phy_wdata", {16'd0, phy_wr_data}, {16'd0, (wr ? wd : 16'h0000)});
    @(negedge clk);
    check("strobe_width", {31'd0, (phy_reg_wr | phy_reg_rd)}, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 32'd0);
  endtask

  task automatic check_all_zero(input string tag, input logic ready_exp);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, {16'd0, resp_rdata}, 32'd0);
    check({tag, "_resp_timeout"}, {31'd0, resp_timeout}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_tcount"}, {24'd0, timeout_count}, 32'd0);
    check({tag, "_addr"}, {27'd0, phy_reg_addr}, 32'd0);
    check({tag, "_wdata"}, {16'd0, phy_wr_data}, 32'd0);
    check({tag, "_strobes"}, {31'd0, (phy_reg_wr | phy_reg_rd)}, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready}, {31'd0, ready_exp});
  endtask

  // Directed sequence.
  initial begin
    int s, s1, s2, d, n, base;
    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 5'd0;
    req_wdata = 16'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset", 1'b1);
    rst = 1'b0;

    // Write, transceiver busy 100 cycles.
    send(1'b1, 5'h00, 16'h1140, 100, 16'h0000, 1'b0, s);
    drain();
    // Read returning 0x0022; write data must be ignored.
    send(1'b0, 5'h02, 16'h1234, 10, 16'h0022, 1'b0, s);
    drain();
    // Busy falls exactly as the counter saturates: normal completion.
    send(1'b0, 5'h1F, 16'h0000, TMO, 16'hBEEF, 1'b0, s);
    drain();
    // One cycle longer than that: timeout while still busy.
    send(1'b1, 5'h11, 16'h5555, TMO + 1, 16'h0000, 1'b0, s);
    drain();

    // Transceiver busy when the request is presented.
    @(negedge clk);
    force_busy = 1'b1;
    req_write = 1'b0;
    req_addr  = 5'h06;
    req_valid = 1'b1;
    base = strb_seen;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("busy_req_ready", {31'd0, req_ready}, 32'd0);
    end
    check("busy_req_strobe", strb_seen - base, 32'd0);
    d = cyc + 1;
    @(posedge clk);
    #1 force_busy = 1'b0;
    send(1'b0, 5'h06, 16'h0000, 4, 16'h00AB, 1'b0, s);
    check("busy_req_accept", s, d + 1);
    drain();

    // Back-to-back with req_valid held across the first response.
    base = strb_seen;
    send(1'b0, 5'h03, 16'h0000, 5, 16'h7788, 1'b1, s1);
    send(1'b1, 5'h04, 16'hCAFE, 3, 16'h0000, 1'b0, s2);
    check("b2b_accept", s2, s1 + 5 + 4);
    drain();
    repeat (4) @(negedge clk);
    check("b2b_strobes", strb_seen - base, 32'd2);

    // Reset during WAIT_LO: drop the request, outputs clear at once.
    send(1'b1, 5'h07, 16'h0F0F, 40, 16'h0000, 1'b0, s);
    repeat (5) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst", 1'b0);
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    void'(tc_q.pop_back());
    tc_model = 0;
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    @(negedge clk);
    while (model_busy && n < 200) begin
      check("midrst_ready_low", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    check("midrst_ready_high", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);

    // Silent transceiver: timeouts, then saturation of the count.
    send(1'b0, 5'h09, 16'h0000, 0, 16'h0000, 1'b0, s);
    drain();
    check("tcount_first", {24'd0, timeout_count}, 32'd1);
    for (int i = 1; i < 300; i++) begin
      send(1'(i & 1), 5'($urandom_range(0, 31)), 16'($urandom), 0, 16'h0000, 1'b0, s);
    end
    drain();
    check("tcount_sat", {24'd0, timeout_count}, 32'd255);
    check("strobe_total", strb_seen, strb_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
